bus_invert_decoder: RTL and testbench

//   Receive-side decoder for the bus-invert interface. Each transfer carries an

---
 rtl/bus_invert_decoder.sv | 91 +++++++++
 tb/tb_bus_invert_decoder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bus_invert_decoder.sv
// Bus-invert receive decoder: restores in_data ^ {N{in_inv}} into a 2-entry FIFO and counts inverted transfers.
// Latency: one cycle from push into an empty FIFO to out_valid/out_data; no bypass path.
// Backpressure: in_ready drops only when both entries are held; it comes from registered state alone.
module bus_invert_decoder #(
    parameter int N_BITS   = 8,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_BITS-1:0]   in_data,
    input  logic                in_inv,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N_BITS-1:0]   out_data,
    input  logic                clear_cnt,
    output logic [CNT_BITS-1:0] inv_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    state_t            state;
    state_t            state_nxt;
    logic [N_BITS-1:0] tail_q;
    logic [N_BITS-1:0] dec_data;
    logic              push;
    logic              pop;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign dec_data  = in_data ^ {N_BITS{in_inv}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (push) state_nxt = ONE;
            ONE: begin
                if (push && !pop)      state_nxt = FULL;
                else if (pop && !push) state_nxt = EMPTY;
            end
            FULL:    if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // out_data is the head register; tail_q only holds the second word while FULL.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data <= '0;
            tail_q   <= '0;
        end else begin
            case (state)
                EMPTY: if (push) out_data <= dec_data;
                ONE: begin
                    if (push && pop) out_data <= dec_data;
                    else if (push)   tail_q   <= dec_data;
                end
                FULL:    if (pop) out_data <= tail_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inv_count <= '0;
        end else if (clear_cnt) begin
            inv_count <= '0;
        end else if (push && in_inv && (inv_count != CNT_MAX)) begin
            inv_count <= inv_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_invert_decoder.sv
// Directed bench for bus_invert_decoder with a 4-bit counter so saturation is reachable.
module tb_bus_invert_decoder;

    localparam int N_BITS   = 8;
    localparam int CNT_BITS = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [N_BITS-1:0]   in_data;
    logic                in_inv;
    logic                out_valid;
    logic                out_ready;
    logic [N_BITS-1:0]   out_data;
    logic                clear_cnt;
    logic [CNT_BITS-1:0] inv_count;

    int n_cmp  = 0;
    int n_fail = 0;

    bus_invert_decoder #(.N_BITS(N_BITS), .CNT_BITS(CNT_BITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .clear_cnt (clear_cnt),
        .inv_count (inv_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic vld, input logic [7:0] dat,
                           input logic rdy, input logic [3:0] cnt);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, vld});
        chk({tag, ".out_data"},  {24'd0, out_data},  {24'd0, dat});
        chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, rdy});
        chk({tag, ".inv_count"}, {28'd0, inv_count}, {28'd0, cnt});
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_inv    = 1'b0;
        out_ready = 1'b0;
        clear_cnt = 1'b0;
        step();
        step();
        chk_out("reset", 1'b0, 8'h00, 1'b1, 4'd0);
        reset = 1'b1;
        step();

        // single inverted word, one cycle latency, then popped
        in_valid = 1'b1; in_data = 8'h3C; in_inv = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0; in_data = 8'hFF;
        chk_out("t2_push", 1'b1, 8'hC3, 1'b1, 4'd1);
        step();
        chk_out("t2_empty_hold", 1'b0, 8'hC3, 1'b1, 4'd1);

        // out_ready is ignored while empty
        step();
        chk_out("t2_idle", 1'b0, 8'hC3, 1'b1, 4'd1);

        // back-to-back words, one per cycle
        in_valid = 1'b1; in_data = 8'hA5; in_inv = 1'b0;
        step();
        chk_out("t3_first", 1'b1, 8'hA5, 1'b1, 4'd1);
        in_data = 8'h0F; in_inv = 1'b1;
        step();
        chk_out("t3_second", 1'b1, 8'hF0, 1'b1, 4'd2);
        in_valid = 1'b0;
        step();
        chk_out("t3_drained", 1'b0, 8'hF0, 1'b1, 4'd2);

        // backpressure: fill to FULL, third word stalls
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h11; in_inv = 1'b0;
        step();
        chk_out("t4_one", 1'b1, 8'h11, 1'b1, 4'd2);
        in_data = 8'h22;
        step();
        chk_out("t4_full", 1'b1, 8'h11, 1'b0, 4'd2);
        in_data = 8'h33; in_inv = 1'b1;
        step();
        chk_out("t4_stall", 1'b1, 8'h11, 1'b0, 4'd2);
        out_ready = 1'b1;
        step();
        chk_out("t4_pop1", 1'b1, 8'h22, 1'b1, 4'd2);
        in_inv = 1'b0;
        // push 0x33 while popping 0x22: stays ONE, new word becomes head
        step();
        chk_out("t5_push_pop", 1'b1, 8'h33, 1'b1, 4'd2);
        in_valid = 1'b0;
        step();
        chk_out("t4_drained", 1'b0, 8'h33, 1'b1, 4'd2);

        // counter: clear, then saturate at 15 with 17 inverted words
        clear_cnt = 1'b1;
        step();
        clear_cnt = 1'b0;
        chk("t6_clear", {28'd0, inv_count}, 32'd0);
        in_valid = 1'b1; in_inv = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = 8'(i);
            step();
            chk($sformatf("t6_cnt%0d", i), {28'd0, inv_count}, (i + 1 > 15) ? 32'd15 : 32'(i + 1));
            chk($sformatf("t6_dat%0d", i), {24'd0, out_data}, {24'd0, ~8'(i)});
        end
        in_data = 8'h00; clear_cnt = 1'b1;
        step();
        clear_cnt = 1'b0; in_valid = 1'b0;
        chk_out("t6_clear_prio", 1'b1, 8'hFF, 1'b1, 4'd0);
        step();
        chk_out("t6_drained", 1'b0, 8'hFF, 1'b1, 4'd0);

        // asynchronous reset with FIFO full, checked before the next edge
        out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b1; in_data = 8'h0F;
        step();
        in_data = 8'h55;
        step();
        chk_out("t1_full", 1'b1, 8'hF0, 1'b0, 4'd2);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk_out("t1_async", 1'b0, 8'h00, 1'b1, 4'd0);
        step();
        reset = 1'b1;
        chk_out("t1_held", 1'b0, 8'h00, 1'b1, 4'd0);

        // resumes from EMPTY; discarded tail does not reappear
        in_valid = 1'b1; in_inv = 1'b0; in_data = 8'h5A; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk_out("t1_resume", 1'b1, 8'h5A, 1'b1, 4'd0);
        step();
        chk_out("t1_no_stale", 1'b0, 8'h5A, 1'b1, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
